// File: rtl/line_mem_if.sv
// Line-based cache memory bus between a cache's mem_* port and its backing store.
//   master : cache side   -> drives mem_read, mem_write, mem_addr, mem_wdata
//                            and receives mem_rdata, mem_ready
//   slave  : memory side  -> receives the request and returns mem_rdata, mem_ready
// mem_read/mem_write are held by the master until the one-cycle mem_ready pulse.
interface line_mem_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) ();
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory responder. Services 128-bit line reads and
// write-backs from a cache with a DRAM-like latency of LATENCY cycles from the
// request sample to a single-cycle mem_ready pulse.
//
// Ports:
//   clk        clock
//   proc_reset synchronous active-high reset (storage contents are kept)
//   bus        line_mem_if.slave : mem_read, mem_write, mem_addr, mem_wdata in;
//              mem_rdata, mem_ready out
//   proto_err  sticky flag, set when read and write are requested together
//   rd_count   (LINE_MEM_STATS_EN only) saturating count of completed reads
//   wr_count   (LINE_MEM_STATS_EN only) saturating count of completed writes
//
// Optional feature macro: LINE_MEM_STATS_EN adds rd_count/wr_count.
//
// State table:
//   IDLE | waiting for a request; the only state that samples the bus
//   WAIT | latency countdown on latched op/index/wdata
//   RESP | one-cycle completion, mem_ready high
module line_mem_responder #(
    parameter int ADDR_W     = 28,
    parameter int DATA_W     = 128,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic           clk,
    input  logic           proc_reset,
    line_mem_if.slave      bus,
`ifdef LINE_MEM_STATS_EN
    output logic [15:0]    rd_count,
    output logic [15:0]    wr_count,
`endif
    output logic           proto_err
);

    localparam int         DEPTH   = 1 << DEPTH_LOG2;
    localparam bit         LAT_ONE = (LATENCY == 1);
    localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    op_wr;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DATA_W-1:0]       wdata_q;

    logic [DATA_W-1:0]       mem_array [DEPTH];

    logic                    req;
    logic                    acc_go;
    logic                    acc_wr;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic [DATA_W-1:0]       acc_wdata;

    // Upper address bits alias onto the same lines by design.
    logic                    unused_addr_hi;
    assign unused_addr_hi = ^bus.mem_addr[ADDR_W-1:DEPTH_LOG2];

    assign req = bus.mem_read | bus.mem_write;

    // Array access happens on the edge that enters RESP. With LATENCY=1 that
    // edge is the sampling edge itself, so the live bus values are used
    // instead of the (not yet loaded) latched copies. Reset on that same edge
    // suppresses the access so an aborted write is never committed.
    always_comb begin
        acc_go    = 1'b0;
        acc_wr    = op_wr;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        if (!proc_reset) begin
            if (state == IDLE && req && LAT_ONE) begin
                acc_go    = 1'b1;
                acc_wr    = bus.mem_write;
                acc_idx   = bus.mem_addr[DEPTH_LOG2-1:0];
                acc_wdata = bus.mem_wdata;
            end else if (state == WAIT && cnt == 4'd1) begin
                acc_go = 1'b1;
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (acc_go && acc_wr) begin
            mem_array[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            op_wr         <= 1'b0;
            idx_q         <= '0;
            wdata_q       <= '0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            proto_err     <= 1'b0;
        end else begin
            bus.mem_ready <= acc_go;
            if (acc_go && !acc_wr) begin
                bus.mem_rdata <= mem_array[acc_idx];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        // Both requests together are serviced as a write.
                        op_wr   <= bus.mem_write;
                        idx_q   <= bus.mem_addr[DEPTH_LOG2-1:0];
                        wdata_q <= bus.mem_wdata;
                        if (bus.mem_read && bus.mem_write) begin
                            proto_err <= 1'b1;
                        end
                        if (LAT_ONE) begin
                            state <= RESP;
                        end else begin
                            cnt   <= LAT_M1;
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LINE_MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else if (state == RESP) begin
            if (op_wr) begin
                if (wr_count != 16'hFFFF) begin
                    wr_count <= wr_count + 16'd1;
                end
            end else begin
                if (rd_count != 16'hFFFF) begin
                    rd_count <= rd_count + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed self-checking bench for line_mem_responder (LATENCY=4, DEPTH_LOG2=8).
// Cycle 0 of a transaction is the cycle in which the request is first driven;
// it is sampled at the end of that cycle, so mem_ready is expected in cycle 4.
module tb_line_mem_responder;

    localparam logic [127:0] D1  = 128'hDEADBEEF_00000001_00000002_00000003;
    localparam logic [127:0] P20 = 128'h20202020_11111111_22222222_33333333;
    localparam logic [127:0] P10 = 128'h10101010_AAAAAAAA_BBBBBBBB_CCCCCCCC;

    logic clk = 1'b0;
    logic proc_reset;
    logic proto_err;
`ifdef LINE_MEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_mem_if #(.ADDR_W(28), .DATA_W(128)) bus ();

    line_mem_responder #(
        .ADDR_W    (28),
        .DATA_W    (128),
        .DEPTH_LOG2(8),
        .LATENCY   (4)
    ) dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .bus       (bus),
`ifdef LINE_MEM_STATS_EN
        .rd_count  (rd_count),
        .wr_count  (wr_count),
`endif
        .proto_err (proto_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, hold it until mem_ready (bounded), then drop it.
    task automatic txn(input logic rd, input logic wr, input logic [27:0] addr,
                       input logic [127:0] wd, output int rc, output logic [127:0] rdat);
        tick();
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        rc   = -1;
        rdat = 'x;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus.mem_ready === 1'b1) begin
                rc   = c;
                rdat = bus.mem_rdata;
                break;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        int pulses;
        int p1;
        int p2;
        logic [127:0] rdat;

        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        proc_reset    = 1'b1;
        repeat (3) tick();
        chk("rst_ready", 128'(bus.mem_ready), 128'd0);
        chk("rst_rdata", bus.mem_rdata, 128'd0);
        chk("rst_proto_err", 128'(proto_err), 128'd0);
        proc_reset = 1'b0;

        // Write then read of index 3.
        txn(1'b0, 1'b1, 28'h0000003, D1, rc, rdat);
        chk("wr3_latency", 128'(rc), 128'd4);
        chk("wr3_rdata_unchanged", bus.mem_rdata, 128'd0);
        tick();
        chk("ready_one_cycle", 128'(bus.mem_ready), 128'd0);

        txn(1'b1, 1'b0, 28'h0000003, 128'd0, rc, rdat);
        chk("rd3_latency", 128'(rc), 128'd4);
        chk("rd3_data", rdat, D1);
        chk("rd3_proto_err", 128'(proto_err), 128'd0);

        // Aliasing: 0x105 and 0x005 share index 5.
        txn(1'b0, 1'b1, 28'h0000105, 128'h1, rc, rdat);
        chk("alias_wr_latency", 128'(rc), 128'd4);
        txn(1'b1, 1'b0, 28'h0000005, 128'd0, rc, rdat);
        chk("alias_rd_data", rdat, 128'h1);

        // Cache-style write-back of 0x10 then refill of 0x20, requests held.
        txn(1'b0, 1'b1, 28'h0000020, P20, rc, rdat);
        chk("pre_wr20_latency", 128'(rc), 128'd4);
        tick();
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h0000010;
        bus.mem_wdata = P10;
        pulses = 0;
        p1     = -1;
        p2     = -1;
        rdat   = 'x;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (bus.mem_ready === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    p1 = c;
                    bus.mem_write = 1'b0;
                    bus.mem_read  = 1'b1;
                    bus.mem_addr  = 28'h0000020;
                end else if (pulses == 2) begin
                    p2   = c;
                    rdat = bus.mem_rdata;
                    bus.mem_read = 1'b0;
                end
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        chk("b2b_pulse_count", 128'(pulses), 128'd2);
        chk("b2b_first_pulse", 128'(p1), 128'd4);
        chk("b2b_second_pulse", 128'(p2), 128'd9);
        chk("b2b_refill_data", rdat, P20);
        txn(1'b1, 1'b0, 28'h0000010, 128'd0, rc, rdat);
        chk("b2b_writeback_data", rdat, P10);

        // Reset during a write to 0x7: write must not commit, no mem_ready.
        txn(1'b0, 1'b1, 28'h0000007, 128'h5A, rc, rdat);
        chk("pre_wr7_latency", 128'(rc), 128'd4);
        tick();
        bus.mem_write = 1'b1;
        bus.mem_addr  = 28'h0000007;
        bus.mem_wdata = 128'hA5;
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (bus.mem_ready === 1'b1) pulses++;
            if (c == 2) begin
                proc_reset    = 1'b1;
                bus.mem_write = 1'b0;
            end
            if (c == 3) proc_reset = 1'b0;
        end
        chk("abort_no_ready", 128'(pulses), 128'd0);
        txn(1'b1, 1'b0, 28'h0000007, 128'd0, rc, rdat);
        chk("abort_rd7_latency", 128'(rc), 128'd4);
        chk("abort_rd7_data", rdat, 128'h5A);
        chk("abort_proto_err", 128'(proto_err), 128'd0);

        // Read and write together: serviced as write, sticky proto_err.
        txn(1'b1, 1'b1, 28'h0000009, 128'h77, rc, rdat);
        chk("both_latency", 128'(rc), 128'd4);
        chk("both_proto_err", 128'(proto_err), 128'd1);
        chk("both_rdata_unchanged", bus.mem_rdata, 128'h5A);
        txn(1'b1, 1'b0, 28'h0000009, 128'd0, rc, rdat);
        chk("both_rd9_data", rdat, 128'h77);
        chk("proto_err_sticky", 128'(proto_err), 128'd1);

        proc_reset = 1'b1;
        tick();
        tick();
        proc_reset = 1'b0;
        chk("rst2_proto_err", 128'(proto_err), 128'd0);
        chk("rst2_rdata", bus.mem_rdata, 128'd0);

`ifdef LINE_MEM_STATS_EN
        chk("stats_rst_rd", 128'(rd_count), 128'd0);
        chk("stats_rst_wr", 128'(wr_count), 128'd0);
        txn(1'b1, 1'b0, 28'h0000003, 128'd0, rc, rdat);
        txn(1'b0, 1'b1, 28'h0000030, 128'h30, rc, rdat);
        txn(1'b1, 1'b0, 28'h0000030, 128'd0, rc, rdat);
        txn(1'b0, 1'b1, 28'h0000031, 128'h31, rc, rdat);
        txn(1'b1, 1'b0, 28'h0000031, 128'd0, rc, rdat);
        tick();
        chk("stats_rd_count", 128'(rd_count), 128'd3);
        chk("stats_wr_count", 128'(wr_count), 128'd2);
        proc_reset = 1'b1;
        tick();
        proc_reset = 1'b0;
        chk("stats_clr_rd", 128'(rd_count), 128'd0);
        chk("stats_clr_wr", 128'(wr_count), 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
